// File: rtl/ht_sort.sv
// Purpose: odd-even transposition sorter; captures index unsigned elements on start, sorts ascending.
// Latency: over rises index+1 clk edges after start is first sampled high (one capture edge + index passes).
// Backpressure: level handshake; start held high keeps DONE (sorts once), start low returns to IDLE.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset; clears state, pass counter, over and working register
//   start    - level request to capture indata and sort (ignored outside IDLE/DONE exit)
//   indata   - unpacked array of index elements, element 0 first
//   outdata  - working register; sorted result valid while over=1, intermediate passes otherwise
//   over     - sort complete, held high in DONE
module ht_sort #(
    parameter int index = 8,
    parameter int width = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] indata  [index],
    output logic [width-1:0] outdata [index],
    output logic             over
);

    localparam int CW = $clog2(index + 1);
    localparam logic [CW-1:0] LAST_PASS = CW'(index - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     pass_q,  pass_d;
    logic              over_q,  over_d;
    logic [width-1:0]  data_q   [index];
    logic [width-1:0]  data_d   [index];
    logic [width-1:0]  pass_res [index];

    // One transposition pass over the working register. Even passes pair
    // (0,1),(2,3)...; odd passes pair (1,2),(3,4)... A pair starting at i
    // is active when i's parity matches the pass parity. Unpaired ends hold.
    always_comb begin
        for (int i = 0; i < index; i++) begin
            pass_res[i] = data_q[i];
        end
        for (int i = 0; i + 1 < index; i++) begin
            if ((((i % 2) != 0) == pass_q[0]) && (data_q[i] > data_q[i+1])) begin
                pass_res[i]   = data_q[i+1];
                pass_res[i+1] = data_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        over_d  = over_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                over_d = 1'b0;
                if (start) begin
                    data_d  = indata;
                    pass_d  = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                data_d = pass_res;
                if (pass_q == LAST_PASS) begin
                    state_d = DONE;
                    over_d  = 1'b1;
                end else begin
                    pass_d = pass_q + CW'(1);
                end
            end
            DONE: begin
                over_d = 1'b1;
                // Leave only once start drops, so a held start sorts exactly once.
                if (!start) begin
                    state_d = IDLE;
                    over_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                over_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= '0;
            over_q  <= 1'b0;
            for (int i = 0; i < index; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            over_q  <= over_d;
            for (int i = 0; i < index; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign outdata = data_q;
    assign over    = over_q;

endmodule

// File: tb/tb_ht_sort.sv
module tb_ht_sort;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] indata  [8];
    logic [4:0] outdata [8];
    logic       over;

    int n_chk;
    int n_fail;

    ht_sort #(.index(8), .width(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .indata  (indata),
        .outdata (outdata),
        .over    (over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Build a packed vector with element 0 in the low bits.
    function automatic logic [39:0] mk(input logic [4:0] e0, input logic [4:0] e1,
                                       input logic [4:0] e2, input logic [4:0] e3,
                                       input logic [4:0] e4, input logic [4:0] e5,
                                       input logic [4:0] e6, input logic [4:0] e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [39:0] v);
        for (int i = 0; i < 8; i++) begin
            indata[i] = v[i*5 +: 5];
        end
    endtask

    task automatic check_out(input string tag, input logic [39:0] exp);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(outdata[i]), 32'(exp[i*5 +: 5]));
        end
    endtask

    // Starts from IDLE, raises start and counts edges until over; optionally
    // scrambles indata right after the capture edge to prove it is ignored.
    task automatic run_sort(input string tag, input logic [39:0] vin,
                            input logic [39:0] vexp, input bit scramble);
        int n;
        set_in(vin);
        start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (scramble && n == 1) set_in(~vin);
        end while (!over && n < 20);
        check({tag, "_latency"}, 32'(n), 32'd9);
        check_out(tag, vexp);
    endtask

    initial begin
        logic [39:0] v_a, s_a, v_b, s_b;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        set_in('0);

        // Reset state before any clock edge.
        #3;
        check("reset_over", 32'(over), 32'd0);
        check_out("reset_out", '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_over", 32'(over), 32'd0);

        // 1: mixed input with duplicates, start held.
        v_a = mk(5'h1F, 5'h03, 5'h10, 5'h00, 5'h07, 5'h07, 5'h1A, 5'h02);
        s_a = mk(5'h00, 5'h02, 5'h03, 5'h07, 5'h07, 5'h10, 5'h1A, 5'h1F);
        run_sort("t1", v_a, s_a, 1'b0);
        repeat (3) tick();
        check("t1_over_held", 32'(over), 32'd1);
        check_out("t1_held", s_a);

        // 6a: drop start -> over clears, result retained.
        start = 1'b0;
        tick();
        check("t6_over_drop", 32'(over), 32'd0);
        check_out("t6_retained", s_a);

        // 2: already sorted, no early exit.
        v_b = mk(5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07);
        run_sort("t2", v_b, v_b, 1'b0);
        start = 1'b0;
        tick();

        // 3: reverse order, worst case.
        v_b = mk(5'h1F, 5'h1E, 5'h1D, 5'h1C, 5'h1B, 5'h1A, 5'h19, 5'h18);
        s_b = mk(5'h18, 5'h19, 5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F);
        run_sort("t3", v_b, s_b, 1'b0);
        start = 1'b0;
        tick();

        // 4: all equal.
        v_b = mk(5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h0A);
        run_sort("t4", v_b, v_b, 1'b0);
        start = 1'b0;
        tick();

        // 6b: new data, indata scrambled during SORT must not matter.
        v_b = mk(5'h05, 5'h1C, 5'h00, 5'h13, 5'h09, 5'h09, 5'h01, 5'h1E);
        s_b = mk(5'h00, 5'h01, 5'h05, 5'h09, 5'h09, 5'h13, 5'h1C, 5'h1E);
        run_sort("t6", v_b, s_b, 1'b1);
        start = 1'b0;
        tick();

        // 5: reset mid-sort, then a fresh sort.
        set_in(v_a);
        start = 1'b1;
        repeat (4) tick();
        check("t5_over_mid", 32'(over), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_over", 32'(over), 32'd0);
        check_out("t5_rst_out", '0);
        #1;
        rst_n = 1'b1;
        run_sort("t5", v_a, s_a, 1'b0);
        start = 1'b0;
        tick();
        check("t5_over_drop", 32'(over), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ht_sort.md
Name: ht_sort

Overview:
- Hackathon sorting engine. Captures an array of INDEX unsigned WIDTH-bit values on `start`.
- Sorts them into ascending order with an odd-even transposition network of INDEX passes, one pass per clock.
- Presents the sorted array on `outdata` and flags completion on `over`.
- Sits between a stimulus/data source and any consumer that waits for `over`.

Parameters:
- index, default 8: number of elements; must be >= 1.
- width, default 5: bits per element; values are unsigned.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: level request to capture `indata` and sort.
- indata, input, [width-1:0] x index: unpacked array of elements; element 0 is first.
- outdata, output, [width-1:0] x index: unpacked array driven from the internal working register; valid while `over`=1.
- over, output, 1: sort complete; held high in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, pass counter=0, over=0.
  - All working-register elements, and therefore every `outdata` element, = 0.
  - Reset mid-sort abandons the sort with no residue.
- State machine IDLE, SORT, DONE; registers update on the clk rising edge.
- IDLE:
  - over=0.
  - If start=1 at the edge: copy `indata[0..index-1]` into the working register, clear the pass counter, go to SORT.
  - Otherwise hold.
- SORT, one pass per edge:
  - Pass counter p runs 0..index-1.
  - p even: compare pairs (0,1),(2,3),…
  - p odd: compare pairs (1,2),(3,4),…
  - In each pair, swap when left > right (unsigned); equal values are not swapped.
  - Unpaired end elements hold.
  - On the edge executing p=index-1: go to DONE and set over<=1.
  - `start` and `indata` are ignored during SORT.
- DONE:
  - over=1; working register frozen, so `outdata` is stable and sorted ascending.
  - Stay while start=1.
  - When start=0 at an edge: go to IDLE, over<=0, `outdata` retains the last result.
  - A continuously-held start therefore sorts exactly once.
- Latency:
  - The capture edge is followed by index SORT edges; over rises after the index-th SORT edge, i.e. index+1 edges after start is first sampled high.
  - Default index=8: 9 cycles.
- index=1: one pass with no pairs; over after 2 edges, output equals input.
- `outdata` during SORT shows intermediate pass results; consumers use it only when over=1.
- No arithmetic beyond unsigned compares; the pass counter is $clog2(index+1) bits.
- Parameterised compare/swap network generated by loops: no per-element hardcoding.

Test Plan:
1. Reset, then start=1 held, indata = 1F,03,10,00,07,07,1A,02 → over rises 9 edges after the first sampled start; outdata = 00,02,03,07,07,10,1A,1F; over stays 1 while start is held.
2. Already sorted input 00..07 → outdata unchanged; same latency (9 edges, no early exit).
3. Reverse input 1F,1E,1D,1C,1B,1A,19,18 (worst case) → outdata = 18..1F after exactly 8 passes.
4. All-equal input 0A x8 → outdata all 0A; no swaps; over after 9 edges.
5. Assert rst_n=0 mid-SORT → immediately over=0, outdata all 0, state IDLE. Release with start=1 → fresh capture and a correct sort.
6. After DONE:
   - drop start → over=0 next edge, outdata held;
   - change indata, raise start → new sort completes 9 edges later;
   - indata changes made during SORT have no effect.
